// File: rtl/imm_gen_pkg.sv
// Shared types, RISC-V opcodes and helpers for the pipelined immediate generator.
// Optional CSR zimm support is enabled by defining IMM_GEN_ZIMM_EN.
package imm_gen_pkg;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100,
        IMM_Z = 3'b101
    } imm_sel_t;

    // Select code used internally for "no legal format" (11x are reserved).
    localparam logic [2:0] SEL_RESERVED = 3'b111;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_OPIMM  = 7'h13;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    // Sign-extend a 32-bit value to the widest supported XLEN; callers truncate.
    function automatic logic [63:0] sext(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/imm_gen_pipe_extract.sv
// Combinational immediate extraction: (instr, format select) -> (imm, illegal).
// The CSR zimm format is only legal when IMM_GEN_ZIMM_EN is defined.
module imm_extract
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:7]     instr_i,  // opcode bits never contribute to an immediate
    input  logic [2:0]      sel_i,
    output logic [XLEN-1:0] imm_o,
    output logic            illegal_o
);

    logic        s;
    logic [63:0] imm64;

    assign s = instr_i[31];

    // Build the format-specific immediate at 64 bits, then truncate to XLEN.
    always_comb begin
        imm64     = '0;
        illegal_o = 1'b0;
        case (sel_i)
            IMM_I: imm64 = sext({{20{s}}, instr_i[31:20]});
            IMM_S: imm64 = sext({{20{s}}, instr_i[31:25], instr_i[11:7]});
            IMM_B: imm64 = sext({{20{s}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0});
            IMM_J: imm64 = sext({{12{s}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0});
            IMM_U: imm64 = sext({instr_i[31:12], 12'h000});
`ifdef IMM_GEN_ZIMM_EN
            IMM_Z: imm64 = {59'd0, instr_i[19:15]};
`else
            IMM_Z: illegal_o = 1'b1;
`endif
            default: illegal_o = 1'b1;
        endcase
    end

    assign imm_o = imm64[XLEN-1:0];

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator with valid/ready handshake, a 2-entry
// OUT+SKID buffer, tag pass-through, flush and illegal-format flag.
// Defining IMM_GEN_ZIMM_EN enables the CSR zimm format (sel 101 / SYSTEM funct3[2]).
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned TAG_W       = 5,
    parameter int unsigned AUTO_DECODE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       imm_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             illegal
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    logic [2:0]       sel_eff;
    logic [XLEN-1:0]  ext_imm;
    logic             ext_ill;

    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  out_imm_q, out_imm_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             out_ill_q, out_ill_d;
    logic             skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
    logic             skid_ill_q, skid_ill_d;

    logic accept;
    logic drain;

    // Pick the format: either the explicit select or an opcode decode.
    always_comb begin
        sel_eff = imm_sel;
        if (AUTO_DECODE != 0) begin
            case (instr[6:0])
                OP_OPIMM, OP_LOAD, OP_JALR: sel_eff = IMM_I;
`ifdef IMM_GEN_ZIMM_EN
                OP_SYSTEM:                  sel_eff = instr[14] ? IMM_Z : IMM_I;
`else
                OP_SYSTEM:                  sel_eff = IMM_I;
`endif
                OP_STORE:                   sel_eff = IMM_S;
                OP_BRANCH:                  sel_eff = IMM_B;
                OP_JAL:                     sel_eff = IMM_J;
                OP_LUI, OP_AUIPC:           sel_eff = IMM_U;
                default:                    sel_eff = SEL_RESERVED;
            endcase
        end
    end

    imm_extract #(
        .XLEN (XLEN)
    ) u_extract (
        .instr_i   (instr[31:7]),
        .sel_i     (sel_eff),
        .imm_o     (ext_imm),
        .illegal_o (ext_ill)
    );

    // in_ready depends only on registered state, so no path from out_ready.
    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && in_ready && !flush;
    assign drain    = out_valid_q && out_ready;

    // Next-state for the OUT/SKID pair; FIFO order is OUT before SKID.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_tag_d    = out_tag_q;
        out_ill_d    = out_ill_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_tag_d   = skid_tag_q;
        skid_ill_d   = skid_ill_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || drain) begin
            if (skid_valid_q) begin
                // accept is impossible here: in_ready was low.
                out_valid_d  = 1'b1;
                out_imm_d    = skid_imm_q;
                out_tag_d    = skid_tag_q;
                out_ill_d    = skid_ill_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = accept;
                if (accept) begin
                    out_imm_d = ext_imm;
                    out_tag_d = in_tag;
                    out_ill_d = ext_ill;
                end
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_imm_d   = ext_imm;
            skid_tag_d   = in_tag;
            skid_ill_d   = ext_ill;
        end
    end

    // State registers; reset empties both entries immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_tag_q    <= '0;
            out_ill_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_tag_q   <= '0;
            skid_ill_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_tag_q    <= out_tag_d;
            out_ill_q    <= out_ill_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_tag_q   <= skid_tag_d;
            skid_ill_q   <= skid_ill_d;
        end
    end

    assign out_valid = out_valid_q;
    assign imm       = out_imm_q;
    assign out_tag   = out_tag_q;
    assign illegal   = out_ill_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: three instances share the inputs
// (XLEN=32 select-driven, XLEN=64 select-driven, XLEN=32 auto-decode).
module tb_imm_gen_pipe;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic [31:0]      instr = '0;
    logic [2:0]       imm_sel = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_ready = 1'b0;

    logic             rdy0, rdy1, rdy2, ov0, ov1, ov2, ill0, ill1, ill2;
    logic [31:0]      imm0, imm2;
    logic [63:0]      imm1;
    logic [TAG_W-1:0] tag0, tag1, tag2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W), .AUTO_DECODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy0),
        .instr(instr), .imm_sel(imm_sel), .in_tag(in_tag), .out_valid(ov0),
        .out_ready(out_ready), .imm(imm0), .out_tag(tag0), .illegal(ill0));
    imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W), .AUTO_DECODE(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
        .instr(instr), .imm_sel(imm_sel), .in_tag(in_tag), .out_valid(ov1),
        .out_ready(out_ready), .imm(imm1), .out_tag(tag1), .illegal(ill1));
    imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W), .AUTO_DECODE(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy2),
        .instr(instr), .imm_sel(imm_sel), .in_tag(in_tag), .out_valid(ov2),
        .out_ready(out_ready), .imm(imm2), .out_tag(tag2), .illegal(ill2));

    // Reference: immediate value as a signed number built from weighted fields.
    function automatic logic [63:0] model_imm(input logic [31:0] ins, input logic [2:0] sel,
                                              output bit ill);
        longint v;
        v   = 0;
        ill = 0;
        case (sel)
            3'd0: v = longint'(ins[31:20]) - (ins[31] ? 64'sd4096 : 64'sd0);
            3'd1: v = longint'(ins[31:25]) * 32 + longint'(ins[11:7])
                      - (ins[31] ? 64'sd4096 : 64'sd0);
            3'd2: v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
                      + longint'(ins[11:8]) * 2 - (ins[31] ? 64'sd4096 : 64'sd0);
            3'd3: v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
                      + longint'(ins[30:21]) * 2 - (ins[31] ? 64'sd1048576 : 64'sd0);
            3'd4: v = longint'(ins[31:12]) * 4096 - (ins[31] ? 64'sd4294967296 : 64'sd0);
`ifdef IMM_GEN_ZIMM_EN
            3'd5: v = longint'(ins[19:15]);
`endif
            default: ill = 1;
        endcase
        return ill ? 64'd0 : 64'(v);
    endfunction

    // Reference opcode map for auto-decode; 7 stands for "no legal format".
    function automatic logic [2:0] model_auto_sel(input logic [31:0] ins);
        case (ins[6:0])
            7'h13, 7'h03, 7'h67: return 3'd0;
`ifdef IMM_GEN_ZIMM_EN
            7'h73: return ins[14] ? 3'd5 : 3'd0;
`else
            7'h73: return 3'd0;
`endif
            7'h23: return 3'd1;
            7'h63: return 3'd2;
            7'h6F: return 3'd3;
            7'h37, 7'h17: return 3'd4;
            default: return 3'd7;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        total += 5;
        if (ov0 !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b want 0", ov0); end
        if (imm0 !== 32'h0) begin bad++; $display("FAIL reset_imm got %h want 0", imm0); end
        if (tag0 !== '0) begin bad++; $display("FAIL reset_tag got %h want 0", tag0); end
        if (ill0 !== 1'b0) begin bad++; $display("FAIL reset_illegal got %b want 0", ill0); end
        if (rdy0 !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b want 1", rdy0); end
        #3 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_formats();
        logic [31:0] vi [9] = '{32'h80000000, 32'h7FF00000, 32'h7F000F80, 32'h80000080,
                                32'h800000EF, 32'h12345037, 32'h80000037, 32'h12345678,
                                32'hABCDEF01};
        logic [2:0]  vs [9] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd7, 3'd6};
        logic [63:0] ve [9] = '{64'hFFFFFFFFFFFFF800, 64'h7FF, 64'h7FF, 64'hFFFFFFFFFFFFF800,
                                64'hFFFFFFFFFFF00000, 64'h12345000, 64'hFFFFFFFF80000000,
                                64'h0, 64'h0};
        bit          vl [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; instr = vi[i]; imm_sel = vs[i]; in_tag = TAG_W'(i);
            tick();
            in_valid = 1'b0;
            total += 4;
            if (ov0 !== 1'b1 || tag0 !== TAG_W'(i)) begin
                bad++; $display("FAIL fmt%0d_valid_tag got %b/%h want 1/%h", i, ov0, tag0, i);
            end
            if (imm0 !== ve[i][31:0]) begin
                bad++; $display("FAIL fmt%0d_imm32 got %h want %h", i, imm0, ve[i][31:0]);
            end
            if (ill0 !== vl[i]) begin
                bad++; $display("FAIL fmt%0d_illegal got %b want %b", i, ill0, vl[i]);
            end
            if (imm1 !== ve[i]) begin
                bad++; $display("FAIL fmt%0d_imm64 got %h want %h", i, imm1, ve[i]);
            end
        end
        tick();
    endtask

    task automatic test_zimm_and_auto();
        logic [31:0] ai [4] = '{32'h80000063, 32'h00105073, 32'h0000007F, 32'h000FD073};
        logic [63:0] e;
        bit          l;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; instr = ai[i]; imm_sel = 3'd5;
            e = model_imm(ai[i], model_auto_sel(ai[i]), l);
            tick();
            in_valid = 1'b0;
            total += 2;
            if (imm2 !== e[31:0] || ill2 !== l) begin
                bad++; $display("FAIL auto%0d got %h/%b want %h/%b", i, imm2, ill2, e[31:0], l);
            end
            e = model_imm(ai[i], 3'd5, l);
            if (imm0 !== e[31:0] || ill0 !== l) begin
                bad++; $display("FAIL zsel%0d got %h/%b want %h/%b", i, imm0, ill0, e[31:0], l);
            end
        end
        total += 1;
        if (imm2 !== 32'h0 || ill2 !== 1'b0) begin end
        if (ai[0] == 32'h80000063) begin
            e = model_imm(ai[0], 3'd2, l);
            if (e[31:0] !== 32'hFFFFF000) begin
                bad++; $display("FAIL auto_branch_model got %h want FFFFF000", e[31:0]);
            end
        end
        tick();
    endtask

    task automatic test_random_stream();
        logic [6:0]  ops [9] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17};
        logic [63:0] e;
        bit          l;
        out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            in_valid = 1'b1;
            instr    = $urandom;
            if ($urandom_range(0, 3) != 0) instr[6:0] = ops[$urandom_range(0, 8)];
            imm_sel  = 3'($urandom_range(0, 7));
            in_tag   = TAG_W'($urandom);
            tick();
            total += 3;
            e = model_imm(instr, imm_sel, l);
            if (ov0 !== 1'b1 || imm0 !== e[31:0] || ill0 !== l || tag0 !== in_tag) begin
                bad++; $display("FAIL rnd%0d_x32 got %b %h %b %h want 1 %h %b %h", i, ov0, imm0,
                                ill0, tag0, e[31:0], l, in_tag);
            end
            if (imm1 !== e || ill1 !== l) begin
                bad++; $display("FAIL rnd%0d_x64 got %h %b want %h %b", i, imm1, ill1, e, l);
            end
            e = model_imm(instr, model_auto_sel(instr), l);
            if (imm2 !== e[31:0] || ill2 !== l) begin
                bad++; $display("FAIL rnd%0d_auto got %h %b want %h %b", i, imm2, ill2, e[31:0], l);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        int got [$];
        bool_loop: begin end
        out_ready = 1'b0; in_valid = 1'b1; imm_sel = 3'd0; instr = 32'h00100013;
        in_tag = 5'd1;
        tick();
        total += 1;
        if (rdy0 !== 1'b1 || ov0 !== 1'b1) begin
            bad++; $display("FAIL bp_after_tag1 got rdy=%b ov=%b want 1 1", rdy0, ov0);
        end
        in_tag = 5'd2;
        tick();
        in_tag = 5'd3;
        total += 1;
        if (rdy0 !== 1'b0) begin bad++; $display("FAIL bp_full_ready got %b want 0", rdy0); end
        tick();
        total += 1;
        if (rdy0 !== 1'b0) begin bad++; $display("FAIL bp_hold_ready got %b want 0", rdy0); end
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (ov0) got.push_back(int'(tag0));
            if (in_valid && rdy0) begin
                tick();
                in_valid = 1'b0;
            end else begin
                tick();
            end
        end
        total += 1;
        if (got.size() != 3 || got[0] != 1 || got[1] != 2 || got[2] != 3) begin
            bad++; $display("FAIL bp_order got n=%0d %p want 1 2 3", got.size(), got);
        end
    endtask

    typedef struct { logic [31:0] imm; logic [TAG_W-1:0] tag; bit ill; } ent_t;

    task automatic test_random_backpressure();
        ent_t q [$];
        ent_t n;
        logic [63:0] e;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
            instr     = $urandom;
            imm_sel   = 3'($urandom_range(0, 7));
            in_tag    = TAG_W'($urandom);
            #1;
            if (ov0 && out_ready) begin
                total += 1;
                if (q.size() == 0) begin
                    bad++; $display("FAIL sb%0d_spurious got tag %h want none", i, tag0);
                end else begin
                    n = q.pop_front();
                    if (imm0 !== n.imm || tag0 !== n.tag || ill0 !== n.ill) begin
                        bad++; $display("FAIL sb%0d_data got %h %h %b want %h %h %b", i, imm0,
                                        tag0, ill0, n.imm, n.tag, n.ill);
                    end
                end
            end
            if (in_valid && rdy0) begin
                e = model_imm(instr, imm_sel, n.ill);
                n.imm = e[31:0];
                n.tag = in_tag;
                q.push_back(n);
            end
            tick();
            total += 1;
            if (ov0 !== (q.size() > 0) || rdy0 !== (q.size() < 2)) begin
                bad++; $display("FAIL sb%0d_occupancy got ov=%b rdy=%b want held=%0d", i, ov0,
                                rdy0, q.size());
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4 && q.size() > 0; c++) begin
            n = q.pop_front();
            total += 1;
            if (ov0 !== 1'b1 || imm0 !== n.imm || tag0 !== n.tag) begin
                bad++; $display("FAIL sb_drain got %b %h %h want 1 %h %h", ov0, imm0, tag0,
                                n.imm, n.tag);
            end
            tick();
        end
        total += 1;
        if (q.size() != 0 || ov0 !== 1'b0) begin
            bad++; $display("FAIL sb_empty got left=%0d ov=%b want 0 0", q.size(), ov0);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1; imm_sel = 3'd0; instr = 32'h00500013;
        tick(); tick();
        total += 1;
        if (rdy0 !== 1'b0 || ov0 !== 1'b1) begin
            bad++; $display("FAIL flush_pre got rdy=%b ov=%b want 0 1", rdy0, ov0);
        end
        flush = 1'b1;
        tick();
        total += 2;
        if (ov0 !== 1'b0) begin bad++; $display("FAIL flush_out_valid got %b want 0", ov0); end
        if (rdy0 !== 1'b1) begin bad++; $display("FAIL flush_in_ready got %b want 1", rdy0); end
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        total += 1;
        if (ov0 !== 1'b0) begin bad++; $display("FAIL flush_priority got %b want 0", ov0); end
        tick();
    endtask

    task automatic test_reset_midop();
        out_ready = 1'b0; in_valid = 1'b1; imm_sel = 3'd4; instr = 32'hFFFFF037;
        tick();
        in_valid = 1'b0;
        total += 1;
        if (ov0 !== 1'b1) begin bad++; $display("FAIL midop_pre got %b want 1", ov0); end
        #2 rst_n = 1'b0;
        #1;
        total += 2;
        if (ov0 !== 1'b0) begin bad++; $display("FAIL midop_async got %b want 0", ov0); end
        if (imm0 !== 32'h0 || rdy0 !== 1'b1) begin
            bad++; $display("FAIL midop_regs got imm=%h rdy=%b want 0 1", imm0, rdy0);
        end
        tick();
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            total += 1;
            if (ov0 !== 1'b0 || rdy0 !== 1'b1) begin
                bad++; $display("FAIL midop_after%0d got ov=%b rdy=%b want 0 1", c, ov0, rdy0);
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_formats();
        test_zimm_and_auto();
        test_random_stream();
        test_backpressure();
        test_random_backpressure();
        test_flush();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

endmodule
